// File: rtl/tc_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tc_timer
//  Brief    : Bus-mapped 32-bit down-counting timer with one-shot and
//             auto-reload modes and a maskable level interrupt.
//             Registers: 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (RO), 0xC reserved.
//             Optional prescaler enabled by defining TC_PRESCALE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

`ifdef TC_PRESCALE_EN
    // EN, MODE, IM plus the prescale field in [15:8]
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF0F;
`else
    // EN, MODE, IM only; everything else reads back as 0
    localparam logic [31:0] CTRL_MASK = 32'h0000_000F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        en;
    logic        auto_reload;
    logic        im;
    logic        step;
    logic        wr_ctrl;
    logic        wr_preset;

    // Only Addr[3:2] selects a register; the bridge already qualified the window
    logic        unused_addr_bits;
    assign unused_addr_bits = ^Addr[31:4];

    assign en          = ctrl_q[0];
    // MODE 1x behaves like one-shot, so only the exact 01 encoding reloads
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign im          = ctrl_q[3];
    assign wr_ctrl     = WE && (Addr[3:2] == ADDR_CTRL);
    assign wr_preset   = WE && (Addr[3:2] == ADDR_PRESET);

`ifdef TC_PRESCALE_EN
    logic [7:0] div_q, div_d;
    logic [7:0] ps;
    assign ps   = ctrl_q[15:8];
    // A count step happens only when the divider has run down to zero
    assign step = (div_q == 8'd0);
`else
    assign step = 1'b1;
`endif

    // Next-state for the FSM and datapath, with the bus write applied last so it wins
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
`ifdef TC_PRESCALE_EN
        div_d    = div_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                flag_d  = 1'b0;
`ifdef TC_PRESCALE_EN
                div_d   = ps;
`endif
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (step) begin
`ifdef TC_PRESCALE_EN
                    div_d = ps;
`endif
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // Saturate at zero: PRESET of 0 or 1 expires after one step
                        count_d = 32'd0;
                        flag_d  = 1'b1;
                        state_d = ST_INT;
                    end
                end else begin
`ifdef TC_PRESCALE_EN
                    div_d = div_q - 8'd1;
`endif
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    // EN stays set so the timer reloads; flag is a 1-cycle pulse
                    flag_d = 1'b0;
                end else begin
                    // One-shot: stop, but keep the flag until software clears it
                    ctrl_d[0] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus writes override the FSM's EN clear; any CTRL write clears the flag
        if (wr_ctrl) begin
            ctrl_d = Din & CTRL_MASK;
            flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = Din;
        end
    end

    // State and register update; reset dominates any simultaneous bus write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= 32'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
`ifdef TC_PRESCALE_EN
            div_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
`ifdef TC_PRESCALE_EN
            div_q    <= div_d;
`endif
        end
    end

    // Combinational read mux; the reserved slot reads as zero
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            ADDR_CTRL:   Dout = ctrl_q;
            ADDR_PRESET: Dout = preset_q;
            ADDR_COUNT:  Dout = count_q;
            default:     Dout = 32'd0;
        endcase
    end

    assign IRQ = flag_q & im;

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tc_timer
//  Brief    : Self-checking bench for tc_timer: directed scenarios plus a
//             randomized bus run against a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tc_timer;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

`ifdef TC_PRESCALE_EN
    localparam logic [31:0] C_CTRL_MASK = 32'h0000_FF0F;
`else
    localparam logic [31:0] C_CTRL_MASK = 32'h0000_000F;
`endif

    tc_timer dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One write committed at the next rising edge (E0)
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = {28'h0, a};
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        WE    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v;
        bus_write(2'd1, 32'd7);
        bus_write(2'd0, 32'h9);
        tick(4);
        // reset and a CTRL write in the same cycle: reset must win
        @(negedge clk);
        reset = 1'b1;
        WE    = 1'b1;
        Addr  = {28'h0, 2'd0};
        Din   = 32'hF;
        @(posedge clk);
        #1;
        reset = 1'b0;
        WE    = 1'b0;
        for (int a = 0; a < 4; a++) begin
            Addr = {28'h0, 2'(a)};
            #1;
            exp_v = 32'd0;
            n_checks++;
            if (Dout !== exp_v) begin
                n_errors++;
                $display("FAIL reset_reg%0d: got %h want %h", a, Dout, exp_v);
            end
        end
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_irq: got %b want 0", IRQ);
        end
        tick(3);
        Addr = {28'h0, 2'd2};
        #1;
        n_checks++;
        if (Dout !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_count_idle: got %0d want 0", Dout);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] exp_c;
        do_reset();
        bus_write(2'd1, 32'd5);
        bus_write(2'd0, 32'h9);
        Addr = {28'h0, 2'd2};
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            exp_c = (k < 2) ? 32'd0 : ((k <= 6) ? 32'(7 - k) : 32'd0);
            n_checks++;
            if (Dout !== exp_c) begin
                n_errors++;
                $display("FAIL oneshot_count_E%0d: got %0d want %0d", k, Dout, exp_c);
            end
            n_checks++;
            if (IRQ !== (k == 7)) begin
                n_errors++;
                $display("FAIL oneshot_irq_E%0d: got %b want %b", k, IRQ, (k == 7));
            end
        end
        tick(1);
        Addr = {28'h0, 2'd0};
        #1;
        n_checks++;
        if (Dout !== 32'h8) begin
            n_errors++;
            $display("FAIL oneshot_ctrl_en_clear: got %h want 00000008", Dout);
        end
        tick(5);
        n_checks++;
        if (IRQ !== 1'b1) begin
            n_errors++;
            $display("FAIL oneshot_irq_held: got %b want 1", IRQ);
        end
        bus_write(2'd0, 32'h8);
        n_checks++;
        if (IRQ !== 1'b0) begin
            n_errors++;
            $display("FAIL oneshot_irq_cleared: got %b want 0", IRQ);
        end
    endtask

    task automatic test_autoreload();
        logic exp_i;
        do_reset();
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        Addr = {28'h0, 2'd0};
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp_i = (k >= 5) && (((k - 5) % 6) == 0);
            n_checks++;
            if (IRQ !== exp_i) begin
                n_errors++;
                $display("FAIL auto_irq_E%0d: got %b want %b", k, IRQ, exp_i);
            end
            n_checks++;
            if (Dout !== 32'hB) begin
                n_errors++;
                $display("FAIL auto_ctrl_E%0d: got %h want 0000000b", k, Dout);
            end
        end
    endtask

    task automatic test_preset_zero();
        do_reset();
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            n_checks++;
            if (IRQ !== (k == 3)) begin
                n_errors++;
                $display("FAIL p0_irq_E%0d: got %b want %b", k, IRQ, (k == 3));
            end
        end
        // IM=0: flag may be set but IRQ must stay low
        do_reset();
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            n_checks++;
            if (IRQ !== 1'b0) begin
                n_errors++;
                $display("FAIL p0_masked_irq_E%0d: got %b want 0", k, IRQ);
            end
        end
        Addr = {28'h0, 2'd0};
        #1;
        n_checks++;
        if (Dout !== 32'h0) begin
            n_errors++;
            $display("FAIL p0_masked_ctrl: got %h want 00000000", Dout);
        end
    endtask

    task automatic test_mid_count();
        do_reset();
        bus_write(2'd1, 32'd6);
        bus_write(2'd0, 32'h9);
        Addr = {28'h0, 2'd2};
        tick(4);
        n_checks++;
        if (Dout !== 32'd4) begin
            n_errors++;
            $display("FAIL mid_count_pre: got %0d want 4", Dout);
        end
        // disable lands on the edge where COUNT becomes 3
        bus_write(2'd0, 32'h8);
        Addr = {28'h0, 2'd2};
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick(1);
            #1;
            n_checks++;
            if (Dout !== 32'd3 || IRQ !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_hold_%0d: got count %0d irq %b want 3 0", k, Dout, IRQ);
            end
        end
        // restart, then write PRESET during CNT
        bus_write(2'd0, 32'h9);
        tick(3);
        bus_write(2'd1, 32'd9);
        Addr = {28'h0, 2'd2};
        #1;
        n_checks++;
        if (Dout !== 32'd4) begin
            n_errors++;
            $display("FAIL mid_preset_write: got %0d want 4", Dout);
        end
        tick(1);
        n_checks++;
        if (Dout !== 32'd3) begin
            n_errors++;
            $display("FAIL mid_preset_next: got %0d want 3", Dout);
        end
        // reset while counting aborts everything
        do_reset();
        for (int a = 0; a < 4; a++) begin
            Addr = {28'h0, 2'(a)};
            #1;
            n_checks++;
            if (Dout !== 32'd0) begin
                n_errors++;
                $display("FAIL mid_reset_reg%0d: got %h want 0", a, Dout);
            end
        end
        Addr = {28'h0, 2'd2};
        for (int k = 0; k < 10; k++) begin
            tick(1);
            n_checks++;
            if (IRQ !== 1'b0 || Dout !== 32'd0) begin
                n_errors++;
                $display("FAIL mid_reset_quiet_%0d: got irq %b count %0d want 0 0", k, IRQ, Dout);
            end
        end
    endtask

    task automatic test_decode();
        do_reset();
        bus_write(2'd2, 32'h55);
        bus_write(2'd3, 32'hAA);
        bus_write(2'd1, 32'h1234_5678);
        Addr = {28'h0, 2'd2};
        #1;
        n_checks++;
        if (Dout !== 32'd0) begin
            n_errors++;
            $display("FAIL dec_count_ro: got %h want 0", Dout);
        end
        Addr = {28'h0, 2'd3};
        #1;
        n_checks++;
        if (Dout !== 32'd0) begin
            n_errors++;
            $display("FAIL dec_reserved: got %h want 0", Dout);
        end
        Addr = {28'hABCDEF1, 2'd1};
        #1;
        n_checks++;
        if (Dout !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL dec_upper_addr: got %h want 12345678", Dout);
        end
        // EN=0 write with all other bits set: only implemented fields stick
        bus_write(2'd0, 32'hFFFF_FFF0);
        Addr = {28'h0, 2'd0};
        #1;
        n_checks++;
        if (Dout !== (32'hFFFF_FFF0 & C_CTRL_MASK)) begin
            n_errors++;
            $display("FAIL dec_ctrl_mask: got %h want %h", Dout, 32'hFFFF_FFF0 & C_CTRL_MASK);
        end
    endtask

`ifdef TC_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] exp_tab [0:4];
        exp_tab[0] = 32'd2; exp_tab[1] = 32'd2; exp_tab[2] = 32'd1;
        exp_tab[3] = 32'd1; exp_tab[4] = 32'd0;
        do_reset();
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h0109);
        Addr = {28'h0, 2'd2};
        tick(1);
        for (int k = 2; k <= 6; k++) begin
            tick(1);
            n_checks++;
            if (Dout !== exp_tab[k-2] || IRQ !== (k == 6)) begin
                n_errors++;
                $display("FAIL ps_E%0d: got count %0d irq %b want %0d %b",
                         k, Dout, IRQ, exp_tab[k-2], (k == 6));
            end
        end
    endtask
`endif

    // Reference model: timer phase as an integer (0 idle, 1 load, 2 count, 3 expired)
    task automatic test_random();
        logic [31:0] m_ctrl, m_preset, m_count, n_ctrl, n_preset, n_count, d, exp_d;
        logic [7:0]  m_div, n_div, ps;
        logic        m_flag, n_flag, we;
        logic [1:0]  a;
        int          m_phase, n_phase;
        do_reset();
        m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_div = 0; m_phase = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            we = (($urandom % 6) == 0);
            a  = 2'($urandom % 4);
            d  = $urandom;
            if (a == 2'd1) d = $urandom % 8;
            if (a == 2'd0) begin
                d[0]    = (($urandom % 4) != 0);
                d[15:8] = 8'($urandom % 3);
            end
            WE   = we;
            Addr = {28'($urandom), a};
            Din  = d;

            n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
            n_flag = m_flag; n_div = m_div; n_phase = m_phase;
            ps = m_ctrl[15:8];
            if (m_phase == 0) begin
                if (m_ctrl[0]) n_phase = 1;
            end else if (m_phase == 1) begin
                n_count = m_preset; n_flag = 0; n_div = ps; n_phase = 2;
            end else if (m_phase == 2) begin
                if (!m_ctrl[0]) n_phase = 0;
                else if (m_div != 0) n_div = m_div - 1;
                else begin
                    n_div = ps;
                    if (m_count > 1) n_count = m_count - 1;
                    else begin
                        n_count = 0; n_flag = 1; n_phase = 3;
                    end
                end
            end else begin
                if (m_ctrl[2:1] == 2'b01) n_flag = 0;
                else n_ctrl[0] = 1'b0;
                n_phase = 0;
            end
            if (we && a == 2'd0) begin
                n_ctrl = d & C_CTRL_MASK;
                n_flag = 0;
            end
            if (we && a == 2'd1) n_preset = d;

            @(posedge clk);
            #1;
            m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
            m_flag = n_flag; m_div = n_div; m_phase = n_phase;
            case (a)
                2'd0:    exp_d = m_ctrl;
                2'd1:    exp_d = m_preset;
                2'd2:    exp_d = m_count;
                default: exp_d = 32'd0;
            endcase
            n_checks++;
            if (Dout !== exp_d || IRQ !== (m_flag & m_ctrl[3])) begin
                n_errors++;
                $display("FAIL rand_%0d: got dout %h irq %b want %h %b",
                         i, Dout, IRQ, exp_d, (m_flag & m_ctrl[3]));
            end
        end
        WE = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        do_reset();
        test_reset();
        test_oneshot();
        test_autoreload();
        test_preset_zero();
        test_mid_count();
        test_decode();
`ifdef TC_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
